// File: rtl/fetch_decode_unit.sv
// fetch_decode_unit: fetch/decode/execute sequencer issuing ALU ops and data-memory requests
module fetch_decode_unit #(
  parameter int PROG_LEN = 32,
  parameter bit HALT_ON_WRAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  instruction_address,
  input  logic [15:0] instruction,
  output logic        alu_valid,
  output logic [3:0]  alu_opcode,
  output logic [1:0]  reg_sel,
  output logic [9:0]  operand,
  output logic        mem_req,
  output logic        mem_we,
  output logic [9:0]  mem_addr,
  input  logic        mem_ready,
  output logic        busy,
  output logic        halted,
  output logic        illegal,
  output logic [7:0]  retired
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALT} state_t;
  state_t state;
  logic [4:0] pc;
  logic [15:0] ir;
  logic [3:0] op;
  logic is_alu, is_mem, last, done;
  assign op = ir[15:12];
  assign is_alu = op <= 4'h5 || op == 4'hf;
  assign is_mem = op == 4'h6 || op == 4'h7;
  assign last = pc == 5'(PROG_LEN - 1);
  assign done = alu_valid || (mem_req && mem_ready);
  assign instruction_address = pc;
  assign alu_opcode = op;
  assign reg_sel = ir[11:10];
  assign operand = ir[9:0];
  assign mem_addr = ir[9:0];
  assign mem_we = mem_req && op == 4'h7;
  assign busy = state == FETCH || state == DECODE || state == EXEC;
  assign halted = state == HALT;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      pc <= '0;
      ir <= '0;
      retired <= '0;
      illegal <= 1'b0;
      alu_valid <= 1'b0;
      mem_req <= 1'b0;
    end else
      case (state)
        IDLE, HALT: if (start) begin
          pc <= '0;
          retired <= '0;
          illegal <= 1'b0;
          state <= FETCH;
        end
        FETCH: begin
          ir <= instruction;
          state <= DECODE;
        end
        DECODE: if (is_alu || is_mem) begin
          alu_valid <= is_alu;
          mem_req <= is_mem;
          state <= EXEC;
        end else begin
          illegal <= 1'b1;
          state <= HALT;
        end
        EXEC: if (done) begin
          alu_valid <= 1'b0;
          mem_req <= 1'b0;
          retired <= retired + 8'(retired != 8'hff);
          pc <= last ? (HALT_ON_WRAP ? pc : 5'd0) : pc + 5'd1;
          state <= last && HALT_ON_WRAP ? HALT : FETCH;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: doc/fetch_decode_unit.md
FETCH_DECODE_UNIT -- requirements
Module: fetch_decode_unit

Interface
REQ-001 Parameter PROG_LEN, 32, number of program words; the last address is PROG_LEN-1 (2..32).
REQ-002 Parameter HALT_ON_WRAP, 1, 1 = halt after the word at PROG_LEN-1 retires; 0 = wrap the PC to 0 and continue.
REQ-003 clk  in  1  sole clock; all state changes on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  begin execution at address 0; sampled only in IDLE or HALT.
REQ-006 instruction_address  out  5  PC to program memory (combinational read).
REQ-007 instruction  in  16  word from program memory: [15:12] opcode, [11:10] reg, [9:0] operand.
REQ-008 alu_valid  out  1  one-cycle pulse issuing an ALU op.
REQ-009 alu_opcode  out  4  opcode of the issued op; valid while alu_valid=1.
REQ-010 reg_sel  out  2  register field of the current IR.
REQ-011 operand  out  10  operand field of the current IR.
REQ-012 mem_req  out  1  data-memory request; held until accepted.
REQ-013 mem_we  out  1  1 = STORE, 0 = LOAD; valid with mem_req.
REQ-014 mem_addr  out  10  data-memory address (= operand); valid with mem_req.
REQ-015 mem_ready  in  1  data-memory acceptance; the transfer completes on a cycle where mem_req=1 and mem_ready=1.
REQ-016 busy  out  1  1 in FETCH, DECODE or EXEC.
REQ-017 halted  out  1  1 in HALT.
REQ-018 illegal  out  1  sticky; set when an undefined opcode is decoded.
REQ-019 retired  out  8  count of retired instructions; saturates at 255.

Function
REQ-020 States: IDLE, FETCH, DECODE, EXEC, HALT; one instruction = FETCH -> DECODE -> EXEC (>=1 cycle).
REQ-021 IDLE: on start=1, PC=0, clear retired and illegal, go to FETCH; otherwise stay in IDLE.
REQ-022 FETCH: instruction_address=PC; at the end of the cycle latch instruction into IR; go to DECODE.
REQ-023 instruction_address equals PC in all states.
REQ-024 reg_sel and operand reflect the IR continuously.
REQ-025 Legal opcodes: ALU = 0000 ADD, 0001 SUBTRACT, 0010 AND, 0011 OR, 0100 XOR, 0101 NOT, 1111 TEST; MEM = 0110 LOAD, 0111 STORE.
REQ-026 Opcodes 1000-1110 are illegal.
REQ-027 DECODE: a legal opcode goes to EXEC; an illegal opcode sets illegal=1 and goes to HALT without retiring and without changing the PC.
REQ-028 EXEC, ALU op: alu_valid=1 and alu_opcode=IR[15:12] for exactly one cycle; the instruction retires at the end of that cycle.
REQ-029 EXEC, MEM op: mem_req=1, mem_we=(opcode==0111), mem_addr=IR[9:0]; stay in EXEC while mem_ready=0; retire on the cycle mem_ready=1.
REQ-030 mem_req, mem_we and mem_addr are stable while a MEM op waits.
REQ-031 mem_req deasserts the cycle after acceptance.
REQ-032 A mem_ready that arrives while mem_req=0 is ignored.
REQ-033 Retire: retired increments (saturating at 255); if PC != PROG_LEN-1, PC+1 and go to FETCH.
REQ-034 Retire at PC = PROG_LEN-1: HALT_ON_WRAP=1 -> go to HALT with PC unchanged; HALT_ON_WRAP=0 -> PC=0 and go to FETCH.
REQ-035 HALT: all request outputs are 0; on start=1, behave as in IDLE (PC=0, clear counters, go to FETCH).
REQ-036 start is ignored while busy=1.
REQ-037 ALU op latency: issue 2 cycles after FETCH entry; 3 cycles per ALU instruction.
REQ-038 MEM op: 3 + N cycles, where N = number of EXEC cycles with mem_ready=0.
REQ-039 alu_valid and mem_req are never both 1.
REQ-040 alu_valid and mem_req are both 0 outside EXEC.

Reset
REQ-041 rst=1 at a clock edge forces: IDLE; PC=0; IR=0; retired=0; illegal=0; alu_valid=0, mem_req=0, mem_we=0, busy=0, halted=0.
REQ-042 Reset overrides start and any pending memory wait; mem_req is 0 from the cycle after rst is sampled.
REQ-043 start is not acted on in any cycle with rst=1.

Verification
REQ-044 Program {0:ADD r0 #0, 1:LOAD r1 @0, 2:ADD r1 #0, 3:STORE r1 @0, 4:0x8000}, mem_ready tied 1, start pulse -> alu_valid at cycles 2 and 8 (opcode 0000); mem_req at cycle 5 (we=0, addr=0) and cycle 11 (we=1); illegal=1 and halted=1 at cycle 14; retired=4; instruction_address=4.
REQ-045 LOAD with mem_ready held 0 for 5 EXEC cycles then 1 -> mem_req high for 6 cycles with stable addr/we; retired increments once; PC advances once.
REQ-046 PROG_LEN=4, HALT_ON_WRAP=1, all-ADD program -> 4 alu_valid pulses then HALT with PC=3; with HALT_ON_WRAP=0 -> PC sequence 0,1,2,3,0,1 and no HALT.
REQ-047 rst asserted during a STORE wait (mem_req=1) -> next cycle mem_req=0, state IDLE, PC=0, retired=0; a subsequent start re-executes from address 0.
REQ-048 start pulses during busy -> no effect on PC, retired or state; start in HALT -> illegal cleared, fetch from 0 next cycle.
REQ-049 260 ALU instructions with HALT_ON_WRAP=0 -> retired saturates at 255 and does not wrap.
